// File: rtl/timer_cmp_rd.sv
// Compare/read side of the 64-bit timer: compare register, sticky match interrupt, read mux.
// Define TIMER_RD_SNAPSHOT_EN to make the two-access count read atomic via an upper-half snapshot.
module timer_cmp_rd #(
   parameter logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] cnt,
   input  logic [31:0] wdata,
   input  logic        tcmp0_wr_sel,
   input  logic        tcmp1_wr_sel,
   input  logic        tier_wr_sel,
   input  logic        tisr_wr_sel,
   input  logic        tdr0_rd_sel,
   input  logic        tdr1_rd_sel,
   input  logic        tcmp0_rd_sel,
   input  logic        tcmp1_rd_sel,
   input  logic        tier_rd_sel,
   input  logic        tisr_rd_sel,
   output logic [31:0] rdata,
   output logic        tim_int,
   output logic [31:0] tcmp0,
   output logic [31:0] tcmp1
);

   logic [63:0] cmp;
   logic        int_en;
   logic        int_st;
   logic        match;
   logic        match_q;
   logic [31:0] hi_rd;

   assign match   = (cnt == cmp);
   assign tcmp0   = cmp[31:0];
   assign tcmp1   = cmp[63:32];
   assign tim_int = int_st & int_en;

`ifdef TIMER_RD_SNAPSHOT_EN
   logic [31:0] hi_snap;

   // Upper half frozen by the low-half read so a tdr0/tdr1 pair is coherent.
   always_ff @(posedge clk) begin
      if (rst)
         hi_snap <= '0;
      else if (tdr0_rd_sel)
         hi_snap <= cnt[63:32];
   end

   assign hi_rd = hi_snap;
`else
   assign hi_rd = cnt[63:32];
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         cmp     <= CMP_RST;
         int_en  <= 1'b0;
         int_st  <= 1'b0;
         match_q <= 1'b0;
      end else begin
         match_q <= match;
         if (tcmp0_wr_sel) cmp[31:0]  <= wdata;
         if (tcmp1_wr_sel) cmp[63:32] <= wdata;
         if (tier_wr_sel)  int_en     <= wdata[0];
         // Edge detect keeps a halted counter from re-arming after a clear; set beats W1C.
         if (match && !match_q)
            int_st <= 1'b1;
         else if (tisr_wr_sel && wdata[0])
            int_st <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         rdata <= '0;
      else if (tdr0_rd_sel)
         rdata <= cnt[31:0];
      else if (tdr1_rd_sel)
         rdata <= hi_rd;
      else if (tcmp0_rd_sel)
         rdata <= cmp[31:0];
      else if (tcmp1_rd_sel)
         rdata <= cmp[63:32];
      else if (tier_rd_sel)
         rdata <= {31'b0, int_en};
      else if (tisr_rd_sel)
         rdata <= {31'b0, int_st};
   end

endmodule

// File: tb/tb_timer_cmp_rd.sv
// Bench for timer_cmp_rd: cycle-level register model plus directed scenarios with literal expectations.
module tb_timer_cmp_rd;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [63:0] cnt = '0;
   logic [31:0] wdata = '0;
   logic tcmp0_wr_sel = 0, tcmp1_wr_sel = 0, tier_wr_sel = 0, tisr_wr_sel = 0;
   logic tdr0_rd_sel = 0, tdr1_rd_sel = 0, tcmp0_rd_sel = 0, tcmp1_rd_sel = 0;
   logic tier_rd_sel = 0, tisr_rd_sel = 0;
   logic [31:0] rdata, tcmp0, tcmp1;
   logic        tim_int;

   int total = 0;
   int passed = 0;

   timer_cmp_rd dut (
      .clk(clk), .rst(rst), .cnt(cnt), .wdata(wdata),
      .tcmp0_wr_sel(tcmp0_wr_sel), .tcmp1_wr_sel(tcmp1_wr_sel),
      .tier_wr_sel(tier_wr_sel), .tisr_wr_sel(tisr_wr_sel),
      .tdr0_rd_sel(tdr0_rd_sel), .tdr1_rd_sel(tdr1_rd_sel),
      .tcmp0_rd_sel(tcmp0_rd_sel), .tcmp1_rd_sel(tcmp1_rd_sel),
      .tier_rd_sel(tier_rd_sel), .tisr_rd_sel(tisr_rd_sel),
      .rdata(rdata), .tim_int(tim_int), .tcmp0(tcmp0), .tcmp1(tcmp1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   logic [63:0] m_cmp;
   logic        m_en, m_st, m_prev, m_init = 1'b0;
   logic [31:0] m_rdata, m_snap;
   logic        m_hit;
   logic [31:0] m_hi;

   assign m_hit = (cnt == m_cmp);
`ifdef TIMER_RD_SNAPSHOT_EN
   assign m_hi = m_snap;
`else
   assign m_hi = cnt[63:32];
`endif

   always @(posedge clk) begin
      if (rst) begin
         m_cmp <= 64'hFFFF_FFFF_FFFF_FFFF;
         m_en <= 0; m_st <= 0; m_prev <= 0; m_rdata <= 0; m_snap <= 0;
         m_init <= 1'b1;
      end else begin
         m_prev <= m_hit;
         m_cmp  <= {tcmp1_wr_sel ? wdata : m_cmp[63:32], tcmp0_wr_sel ? wdata : m_cmp[31:0]};
         if (tier_wr_sel) m_en <= wdata[0];
         m_st <= (m_hit && !m_prev) ? 1'b1 : (tisr_wr_sel && wdata[0]) ? 1'b0 : m_st;
         if (tdr0_rd_sel) m_snap <= cnt[63:32];
         if      (tdr0_rd_sel)  m_rdata <= cnt[31:0];
         else if (tdr1_rd_sel)  m_rdata <= m_hi;
         else if (tcmp0_rd_sel) m_rdata <= m_cmp[31:0];
         else if (tcmp1_rd_sel) m_rdata <= m_cmp[63:32];
         else if (tier_rd_sel)  m_rdata <= {31'b0, m_en};
         else if (tisr_rd_sel)  m_rdata <= {31'b0, m_st};
      end
   end

   always @(negedge clk) begin
      if (m_init) begin
         chk("cyc_rdata", {32'b0, rdata}, {32'b0, m_rdata});
         chk("cyc_tim_int", {63'b0, tim_int}, {63'b0, m_st & m_en});
         chk("cyc_tcmp", {tcmp1, tcmp0}, m_cmp);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
      {tcmp0_wr_sel, tcmp1_wr_sel, tier_wr_sel, tisr_wr_sel} = '0;
      {tdr0_rd_sel, tdr1_rd_sel, tcmp0_rd_sel, tcmp1_rd_sel, tier_rd_sel, tisr_rd_sel} = '0;
   endtask

   task automatic wr(input int which, input logic [31:0] d);
      wdata = d;
      case (which)
         0: tcmp0_wr_sel = 1;
         1: tcmp1_wr_sel = 1;
         2: tier_wr_sel  = 1;
         default: tisr_wr_sel = 1;
      endcase
      tick();
   endtask

   initial begin
      // 1: reset, with writes asserted to show reset wins
      rst = 1; wdata = 32'h1234_5678; tcmp0_wr_sel = 1; tier_wr_sel = 1;
      tick(); rst = 1; tick(); rst = 0;
      chk("rst_tcmp0", {32'b0, tcmp0}, 64'hFFFF_FFFF);
      chk("rst_tcmp1", {32'b0, tcmp1}, 64'hFFFF_FFFF);
      chk("rst_rdata", {32'b0, rdata}, 64'h0);
      chk("rst_tim_int", {63'b0, tim_int}, 64'h0);
      tisr_rd_sel = 1; tick();
      chk("rst_tisr_rd", {32'b0, rdata}, 64'h0);

      // 2: compare 0x1_0000_0010, counter ramps through it
      wr(0, 32'h10); wr(1, 32'h1); wr(2, 32'h1);
      cnt = 64'h1_0000_000E; tick();
      cnt = 64'h1_0000_000F; tick();
      chk("ramp_before", {63'b0, tim_int}, 64'h0);
      cnt = 64'h1_0000_0010; tick();
      chk("ramp_hit", {63'b0, tim_int}, 64'h1);
      cnt = 64'h1_0000_0011; tick(); cnt = 64'h1_0000_0012; tick();
      chk("ramp_sticky", {63'b0, tim_int}, 64'h1);
      wr(3, 32'h0);
      chk("w1c_zero_noeff", {63'b0, tim_int}, 64'h1);
      wr(3, 32'h1);
      chk("w1c_clear", {63'b0, tim_int}, 64'h0);

      // 3: halted counter on compare, W1C at cycle 5 must not re-set
      cnt = 64'h1_0000_0010;
      for (int i = 0; i < 20; i++) begin
         if (i == 5) begin wdata = 1; tisr_wr_sel = 1; end
         tick();
         if (i == 0) chk("halt_set", {63'b0, tim_int}, 64'h1);
      end
      chk("halt_no_reset", {63'b0, tim_int}, 64'h0);

      // 4: W1C coincident with rising edge; set wins
      cnt = 64'h0; tick();
      cnt = 64'h1_0000_0010; wdata = 1; tisr_wr_sel = 1; tick();
      chk("set_beats_w1c", {63'b0, tim_int}, 64'h1);
      wr(3, 32'h1);

      // 6: masked interrupt still latches status
      wr(2, 32'h0);
      cnt = 64'h0; tick();
      cnt = 64'h1_0000_0010; tick();
      tisr_rd_sel = 1; tick();
      chk("masked_st", {32'b0, rdata}, 64'h1);
      chk("masked_int", {63'b0, tim_int}, 64'h0);
      wr(2, 32'h1);
      chk("unmask_int", {63'b0, tim_int}, 64'h1);
      wr(2, 32'h0); wr(2, 32'h1);
      chk("mask_not_clear", {63'b0, tim_int}, 64'h1);
      wr(3, 32'h1);

      // compare write equal to current count raises status one cycle after landing
      cnt = 64'h0000_0000_0000_0077;
      wr(0, 32'h77);
      chk("wr_eq_pending", {63'b0, tim_int}, 64'h0);
      wr(1, 32'h0);
      tick();
      chk("wr_eq_set", {63'b0, tim_int}, 64'h1);
      wr(3, 32'h1);

      // wrap to zero with compare 0
      wr(0, 32'h0);
      cnt = 64'hFFFF_FFFF_FFFF_FFFF; tick();
      cnt = 64'h0; tick();
      chk("wrap_match", {63'b0, tim_int}, 64'h1);

      // register reads, priority, same-cycle write/read
      tcmp0_rd_sel = 1; wdata = 32'hCAFE_0001; tcmp0_wr_sel = 1; tick();
      chk("rd_old_on_wr", {32'b0, rdata}, 64'h0);
      tcmp0_rd_sel = 1; tick();
      chk("rd_tcmp0", {32'b0, rdata}, 64'hCAFE_0001);
      tier_rd_sel = 1; tick();
      chk("rd_tier", {32'b0, rdata}, 64'h1);
      tick();
      chk("rd_hold", {32'b0, rdata}, 64'h1);
      cnt = 64'h0000_0005_ABCD_0000;
      tisr_rd_sel = 1; tcmp1_rd_sel = 1; tdr0_rd_sel = 1; tick();
      chk("rd_priority", {32'b0, rdata}, 64'hABCD_0000);

      // 5: atomic 64-bit read across a carry
      cnt = 64'h0000_0001_FFFF_FFFF; tdr0_rd_sel = 1; tick();
      chk("tdr0_low", {32'b0, rdata}, 64'hFFFF_FFFF);
      cnt = 64'h0000_0002_0000_0000; tdr1_rd_sel = 1; tick();
`ifdef TIMER_RD_SNAPSHOT_EN
      chk("tdr1_snap", {32'b0, rdata}, 64'h1);
`else
      chk("tdr1_live", {32'b0, rdata}, 64'h2);
`endif

      // snapshot cleared by reset
      rst = 1; tick(); rst = 0;
      tdr1_rd_sel = 1; tick();
`ifdef TIMER_RD_SNAPSHOT_EN
      chk("tdr1_after_rst", {32'b0, rdata}, 64'h0);
`else
      chk("tdr1_after_rst", {32'b0, rdata}, 64'h2);
`endif
      tick(); tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
